// File: rtl/i_fill_pkg.sv
// Shared constants and types for the instruction-cache line fill path.
// The address range is also used by the cache's own segment-fault check.
package i_fill_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } fill_state_t;

  localparam int          WORDS_PER_LINE = 16;
  localparam logic [31:0] IMEM_BASE      = 32'h0001_0000;
  localparam logic [31:0] IMEM_LIMIT     = 32'h0001_01FF;
  localparam int          TIMEOUT        = 255;

  // Word address of the first word of the line holding addr.
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr & ~(32'(WORDS_PER_LINE) - 32'd1);
  endfunction

endpackage

// File: rtl/i_cache_fill_ctrl.sv
// Instruction-cache miss responder: reads a full line from instruction memory
// one word at a time and presents it to the cache with a one-cycle write strobe.
//
// Memory handshake: mem_rd_en is a single-cycle request carrying mem_addr; memory
// answers with exactly one mem_rvalid pulse (any number of cycles later) carrying
// mem_rdata. mem_addr is held until the next request. fill_ins/fill_addr are only
// meaningful in the cycle fill_wr_en is high.
module i_cache_fill_ctrl #(
  parameter int          WORDS_PER_LINE = i_fill_pkg::WORDS_PER_LINE,
  parameter logic [31:0] IMEM_BASE      = i_fill_pkg::IMEM_BASE,
  parameter logic [31:0] IMEM_LIMIT     = i_fill_pkg::IMEM_LIMIT,
  parameter int          TIMEOUT        = i_fill_pkg::TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [31:0] i_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  output logic [31:0] fill_ins [0:WORDS_PER_LINE-1],
  output logic [31:0] fill_addr,
  output logic        fill_wr_en,
  output logic        busy,
  output logic        fill_err
);
  import i_fill_pkg::*;

  localparam int CNT_W = $clog2(WORDS_PER_LINE);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

  fill_state_t      state;
  fill_state_t      state_nx;
  logic [CNT_W-1:0] word_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             addr_ok;
  logic             last_word;

  assign addr_ok   = (i_addr >= IMEM_BASE) && (i_addr <= IMEM_LIMIT);
  assign last_word = (word_cnt == LAST_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_miss) begin
          state_nx = addr_ok ? REQ : ERR;
        end
      end
      REQ: begin
        state_nx = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_nx = last_word ? DONE : REQ;
        end else if (to_cnt == TO_LAST) begin
          state_nx = ERR;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      ERR: begin
        state_nx = ERR;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Line buffer, counters and addresses. Words not yet written in the current
  // fill keep whatever the previous fill left there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt  <= '0;
      to_cnt    <= '0;
      fill_addr <= '0;
      mem_addr  <= '0;
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        fill_ins[k] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (i_miss && addr_ok) begin
            fill_addr <= line_base(i_addr);
            mem_addr  <= line_base(i_addr);
            word_cnt  <= '0;
          end
        end
        REQ: begin
          to_cnt <= '0;
        end
        WAIT: begin
          if (mem_rvalid) begin
            fill_ins[word_cnt] <= mem_rdata;
            if (!last_word) begin
              word_cnt <= word_cnt + 1'b1;
              mem_addr <= fill_addr + 32'(word_cnt) + 32'd1;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_rd_en  = (state == REQ);
  assign fill_wr_en = (state == DONE);
  assign busy       = (state != IDLE);
  assign fill_err   = (state == ERR);

endmodule

// File: tb/tb_i_cache_fill_ctrl.sv
// Directed-plus-random bench for i_cache_fill_ctrl with a behavioural memory
// and a line/timing reference computed from the fill rules.
module tb_i_cache_fill_ctrl;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam logic [31:0] LIMIT = 32'h0001_01FF;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss;
  logic [31:0] i_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] fill_ins [0:15];
  logic [31:0] fill_addr;
  logic        fill_wr_en;
  logic        busy;
  logic        fill_err;

  // clock / reset / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  i_cache_fill_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .i_miss     (i_miss),
    .i_addr     (i_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .fill_ins   (fill_ins),
    .fill_addr  (fill_addr),
    .fill_wr_en (fill_wr_en),
    .busy       (busy),
    .fill_err   (fill_err)
  );

  // memory model: word content is a scrambled function of its address
  logic        rv_resp;
  logic [31:0] resp_data;
  logic        force_rv;
  logic [31:0] force_data;
  bit          resp_en;
  int          lat_tab [16];
  logic [31:0] salt;
  logic [31:0] resp_a;
  int          resp_l;

  assign mem_rvalid = rv_resp | force_rv;
  assign mem_rdata  = force_rv ? force_data : resp_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  initial begin
    rv_resp   = 1'b0;
    resp_data = '0;
    forever begin
      @(negedge clk);
      if (resp_en && mem_rd_en === 1'b1 && rst === 1'b0) begin
        resp_a = mem_addr;
        resp_l = lat_tab[resp_a[3:0]];
        repeat (resp_l) @(posedge clk);
        #1;
        rv_resp   = 1'b1;
        resp_data = mem_word(resp_a);
        @(posedge clk);
        #1;
        rv_resp = 1'b0;
      end
    end
  end

  // monitor: records every read request and every line write
  logic [31:0] rd_q [$];
  int          wr_cyc_q [$];
  logic [31:0] wr_line [16];
  logic [31:0] wr_addr;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (mem_rd_en === 1'b1) rd_q.push_back(mem_addr);
      if (fill_wr_en === 1'b1) begin
        wr_cyc_q.push_back(cyc);
        wr_addr <= fill_addr;
        for (int k = 0; k < 16; k++) wr_line[k] <= fill_ins[k];
      end
    end
  end

  // scoreboard
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    rd_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Raise a miss in cycle n0; either drop it next cycle, or hold it with a
  // wandering address until the cycle after the line write.
  task automatic run_fill(input logic [31:0] addr, input bit hold, output int n0);
    @(posedge clk);
    #1;
    clear_log();
    i_miss = 1'b1;
    i_addr = addr;
    n0     = cyc;
    if (!hold) begin
      @(posedge clk);
      #1;
      i_miss = 1'b0;
      i_addr = $urandom;
    end else begin
      for (int i = 0; i < 300; i++) begin
        @(posedge clk);
        #1;
        if (wr_cyc_q.size() > 0 && wr_cyc_q[wr_cyc_q.size()-1] == cyc - 1) break;
        i_addr = $urandom;
      end
      i_miss = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy === 1'b1 && n < 500);
    #2;
    chk({tag, " back to idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic check_fill(input string tag, input logic [31:0] addr, input int n0);
    logic [31:0] base;
    int          extra;
    base  = addr & 32'hFFFF_FFF0;
    extra = 0;
    for (int k = 0; k < 16; k++) extra += lat_tab[k] - 1;
    chk({tag, " rd count"}, 32'(rd_q.size()), 32'd16);
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s rd addr %0d", tag, k),
          (rd_q.size() > k) ? rd_q[k] : 32'hDEAD_BEEF, base + 32'(k));
    chk({tag, " wr count"}, 32'(wr_cyc_q.size()), 32'd1);
    chk({tag, " wr cycle"}, (wr_cyc_q.size() > 0) ? 32'(wr_cyc_q[0] - n0) : 32'hFFFF_FFFF,
        32'(33 + extra));
    chk({tag, " wr addr"}, wr_addr, base);
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s line %0d", tag, k), wr_line[k], mem_word(base + 32'(k)));
    chk({tag, " fill_addr held"}, fill_addr, base);
    chk({tag, " word 15 held"}, fill_ins[15], mem_word(base + 32'd15));
    chk({tag, " no error"}, {31'b0, fill_err}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] acc;
    acc = '0;
    for (int k = 0; k < 16; k++) acc |= fill_ins[k];
    chk({tag, " mem_rd_en"}, {31'b0, mem_rd_en}, 32'd0);
    chk({tag, " fill_wr_en"}, {31'b0, fill_wr_en}, 32'd0);
    chk({tag, " busy"}, {31'b0, busy}, 32'd0);
    chk({tag, " fill_err"}, {31'b0, fill_err}, 32'd0);
    chk({tag, " mem_addr"}, mem_addr, 32'd0);
    chk({tag, " fill_addr"}, fill_addr, 32'd0);
    chk({tag, " fill_ins"}, acc, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n0;
    logic [31:0] a;
    logic [31:0] bad_addr [2];

    rst        = 1'b1;
    i_miss     = 1'b0;
    i_addr     = '0;
    force_rv   = 1'b0;
    force_data = '0;
    resp_en    = 1'b1;
    salt       = $urandom;
    for (int k = 0; k < 16; k++) lat_tab[k] = 1;

    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // basic line, rvalid one cycle after every request
    run_fill(32'h0001_0013, 1'b0, n0);
    wait_idle("basic");
    check_fill("basic", 32'h0001_0013, n0);

    // slow memory on word 7 only
    salt       = $urandom;
    lat_tab[7] = 5;
    a          = BASE + 32'($urandom_range(0, 32'h1FF));
    run_fill(a, 1'b0, n0);
    wait_idle("slow7");
    check_fill("slow7", a, n0);

    // random addresses and random per-word latencies
    for (int t = 0; t < 3; t++) begin
      salt = $urandom;
      for (int k = 0; k < 16; k++) lat_tab[k] = $urandom_range(1, 3);
      a = BASE + 32'($urandom_range(0, 32'h1FF));
      run_fill(a, 1'b0, n0);
      wait_idle($sformatf("rand%0d", t));
      check_fill($sformatf("rand%0d", t), a, n0);
    end
    for (int k = 0; k < 16; k++) lat_tab[k] = 1;

    // out-of-range misses: just above the limit, and somewhere below the base
    bad_addr[0] = LIMIT + 32'd1;
    bad_addr[1] = 32'($urandom_range(0, 32'h0000_FFFF));
    for (int t = 0; t < 2; t++) begin
      run_fill(bad_addr[t], 1'b0, n0);
      @(negedge clk);
      chk($sformatf("range%0d err next cycle", t), {31'b0, fill_err}, 32'd1);
      repeat (20) @(negedge clk);
      chk($sformatf("range%0d err sticky", t), {31'b0, fill_err}, 32'd1);
      chk($sformatf("range%0d busy", t), {31'b0, busy}, 32'd1);
      chk($sformatf("range%0d rd count", t), 32'(rd_q.size()), 32'd0);
      chk($sformatf("range%0d wr count", t), 32'(wr_cyc_q.size()), 32'd0);
      do_reset();
    end

    // memory never answers word 0
    resp_en = 1'b0;
    a       = BASE + 32'($urandom_range(0, 32'h1FF));
    run_fill(a, 1'b0, n0);
    while (cyc < n0 + 256) @(negedge clk);
    chk("timeout not yet", {31'b0, fill_err}, 32'd0);
    @(negedge clk);
    chk("timeout err", {31'b0, fill_err}, 32'd1);
    @(posedge clk);
    #1;
    force_rv   = 1'b1;
    force_data = $urandom;
    @(posedge clk);
    #1;
    force_rv = 1'b0;
    repeat (5) @(negedge clk);
    chk("timeout err sticky", {31'b0, fill_err}, 32'd1);
    chk("timeout wr count", 32'(wr_cyc_q.size()), 32'd0);
    chk("timeout rd count", 32'(rd_q.size()), 32'd1);
    resp_en = 1'b1;
    do_reset();

    // reset while word 9 is outstanding
    salt = $urandom;
    a    = BASE + 32'($urandom_range(0, 32'h1FF));
    run_fill(a, 1'b0, n0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_rd_en === 1'b1 && mem_addr[3:0] == 4'd9) break;
    end
    chk("midfill reached word 9", mem_addr, (a & 32'hFFFF_FFF0) + 32'd9);
    rst = 1'b1;
    #1;
    check_all_zero("midfill rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    force_rv   = 1'b1;
    force_data = $urandom;
    @(posedge clk);
    #1;
    force_rv = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("stray rvalid");
    run_fill(32'h0001_0100, 1'b0, n0);
    wait_idle("after rst");
    check_fill("after rst", 32'h0001_0100, n0);

    // miss held high with a wandering address, dropped after the write
    salt = $urandom;
    a    = BASE + 32'($urandom_range(0, 32'h1FF));
    run_fill(a, 1'b1, n0);
    wait_idle("held");
    repeat (40) @(negedge clk);
    check_fill("held", a, n0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/i_cache_fill_ctrl.md
Name: i_cache_fill_ctrl

Overview:
- Memory-side responder that services instruction-cache misses.
- Samples the cache's miss request (i_miss, i_addr) and reads the 16-word line from instruction memory one word at a time.
- Assembles the words in a line buffer, then presents the full line with a one-cycle write strobe that the cache consumes as rd_ins/wr_en.
- Sits between the instruction cache and the instruction memory port. Out-of-range requests and memory timeouts raise a sticky error.

Parameters:
- WORDS_PER_LINE, 16, words per cache line; also the fill burst length.
- IMEM_BASE, 32'h0001_0000, lowest legal instruction word address.
- IMEM_LIMIT, 32'h0001_01FF, highest legal instruction word address.
- TIMEOUT, 255, maximum WAIT cycles without mem_rvalid before error.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- i_miss  in  1  miss request from the instruction cache
- i_addr  in  32  missing word address from the cache
- mem_rdata  in  32  read data from instruction memory
- mem_rvalid  in  1  mem_rdata valid; one pulse per request
- mem_rd_en  out  1  one-cycle read request to memory
- mem_addr  out  32  word address for the current read
- fill_ins  out  32 x [0:15]  assembled line; feeds cache rd_ins
- fill_addr  out  32  line base address (i_addr with [3:0] cleared)
- fill_wr_en  out  1  one-cycle line write strobe; feeds cache wr_en
- busy  out  1  high whenever state is not IDLE
- fill_err  out  1  sticky error flag

Behaviour:
- Reset, asynchronous, active-high:
  - state = IDLE.
  - mem_rd_en, fill_wr_en, busy, fill_err = 0.
  - mem_addr, fill_addr = 0; every fill_ins word = 0.
  - Word counter and timeout counter = 0.
  - Reset mid-fill abandons the fill; a late mem_rvalid after reset is ignored.
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - i_miss=1 with i_addr in [IMEM_BASE, IMEM_LIMIT]: latch fill_addr = {i_addr[31:4],4'h0}, clear word counter, go to REQ.
  - i_miss=1 with i_addr out of range: go to ERR.
  - mem_rvalid is ignored in IDLE.
- REQ:
  - mem_rd_en=1 for exactly this cycle; mem_addr = fill_addr + word counter.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - mem_rd_en=0; mem_addr stays stable.
  - mem_rvalid=1: store mem_rdata into fill_ins[word counter].
    - If word counter = WORDS_PER_LINE-1, go to DONE.
    - Otherwise increment the counter and go to REQ.
  - mem_rvalid=0: increment the timeout counter; when it reaches TIMEOUT, go to ERR.
- DONE:
  - fill_wr_en=1 for exactly one cycle; fill_ins and fill_addr hold stable.
  - Go to IDLE. The cache drops i_miss in the cycle after fill_wr_en; IDLE samples again only in that cycle, so there is no duplicate fill.
- ERR:
  - fill_err=1; absorbing state. Only rst exits.
  - No further mem_rd_en or fill_wr_en.
- i_miss and i_addr changes while busy are ignored. fill_addr is latched once per fill.
- The word counter is 4 bits and never wraps past 15 within a fill.
- Latency with mem_rvalid one cycle after mem_rd_en: i_miss sampled in IDLE at cycle N gives fill_wr_en at N+33.
  - Word k is requested at N+1+2k and captured at N+2+2k.
- fill_ins words not yet written in the current fill keep their previous values. Only fill_wr_en qualifies the line.

Decomposition:
- Shared package i_fill_pkg:
  - fill_state_t enum {IDLE, REQ, WAIT, DONE, ERR}.
  - IMEM_BASE, IMEM_LIMIT, WORDS_PER_LINE constants, shared with the cache's segment-fault range check.
- No sub-module. The line buffer, counters and FSM form a single block.

Test Plan:
- Miss, i_addr=32'h0001_0013; memory returns word = address, rvalid one cycle after each rd_en -> mem_addr steps 0x10010..0x1001F, fill_addr=0x10010, fill_wr_en single pulse at N+33, fill_ins[k]=0x10010+k.
- Same fill with 5-cycle rvalid latency on word 7 only -> word 7 captured correctly, fill_wr_en delayed by exactly 4 cycles, single mem_rd_en per word.
- Miss with i_addr=32'h0001_0200 -> ERR next cycle, fill_err=1 and held, no mem_rd_en ever, busy=1.
- No rvalid for 255 cycles on word 0 -> fill_err=1, no fill_wr_en; a later mem_rvalid has no effect.
- Assert rst during word 9 of a fill -> all outputs 0 immediately; a stray mem_rvalid afterwards is ignored; a new miss at 0x10100 then completes normally with fill_addr=0x10100.
- i_miss held high with a changing i_addr during a fill -> fill_addr unchanged; exactly one fill_wr_en; no second fill if i_miss drops in the cycle after DONE.
